// File: rtl/fifo_axi_pkg.sv
// fifo_axi_pkg -- shared types and constants for the FIFO-to-AXI write master.
//   state_e      : write-master FSM states (IDLE, ADDR, DATA, RESP)
//   RESP_*       : AXI write response codes
//   burst_bytes  : byte span of one burst, used for address stepping
package fifo_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int unsigned burst_bytes(input int unsigned len,
                                              input int unsigned data_w);
    return len * (data_w / 8);
  endfunction

endpackage

// File: rtl/fifo_axi_skid_buf.sv
// fifo_axi_skid_buf -- 2-entry buffer between the write-FIFO read port and AXI W.
//   clk, rst     : clock, asynchronous active-low reset
//   push         : capture push_data this cycle (caller guarantees space)
//   push_data    : word to capture
//   pop          : drop the head entry (caller guarantees valid)
//   valid        : buffer holds at least one entry
//   head         : oldest entry
//   count        : occupancy, 0..2
module fifo_axi_skid_buf #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the two storage words are reset as well; it is only two
      // registers and it keeps wdata at a known zero out of reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign head  = mem[rd_ptr];
  assign count = cnt_q;

endmodule

// File: rtl/fifo_axi_wr_master.sv
// fifo_axi_wr_master -- drains a write FIFO into fixed-length AXI write bursts.
//   clk, rst              : clock, asynchronous active-low reset
//   en                    : start enable, sampled only while idle
//   rd_en/rd_data/empty   : write-FIFO read port (data one cycle after rd_en)
//   awaddr/awlen/awvalid/awready : AW channel, awlen fixed at BURST_LEN-1
//   wdata/wstrb/wlast/wvalid/wready : W channel, wstrb all ones
//   bresp/bvalid/bready   : B channel
//   busy                  : FSM not idle
//   err_cnt               : saturating count of non-OKAY responses
// Build option: define FIFO_AXI_WR_ERR_CNT_EN to include the error counter;
// otherwise err_cnt is tied to zero.
module fifo_axi_wr_master
  import fifo_axi_pkg::*;
#(
  parameter int                 DATA_W    = 128,
  parameter int                 ADDR_W    = 32,
  parameter int                 BURST_LEN = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                rd_en,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                empty,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                busy,
  output logic [15:0]         err_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_STEP =
    ADDR_W'(burst_bytes(int'(BURST_LEN), int'(DATA_W)));
  localparam logic [8:0] POP_MAX   = 9'(BURST_LEN);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_e            state;
  state_e            state_nx;
  logic [8:0]        pop_cnt;
  logic [7:0]        beat_cnt;
  logic              rd_en_q;     // pop issued last cycle, data arriving now
  logic              buf_valid;
  logic [1:0]        buf_count;
  logic [DATA_W-1:0] buf_head;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

  assign awvalid = (state == ST_ADDR);
  assign bready  = (state == ST_RESP);
  assign busy    = (state != ST_IDLE);
  assign awlen   = LAST_BEAT;
  assign wstrb   = '1;

  // Pops are only issued in DATA, so W can never run ahead of the AW
  // handshake. Counting the in-flight pop keeps the buffer from overfilling.
  assign rd_en = (state == ST_DATA) && !empty && (pop_cnt < POP_MAX) &&
                 ((buf_count + {1'b0, rd_en_q}) < 2'd2);

  fifo_axi_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_en_q),
    .push_data (rd_data),
    .pop       (w_hs),
    .valid     (buf_valid),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign wvalid = buf_valid;
  assign wdata  = buf_head;
  assign wlast  = buf_valid && (beat_cnt == LAST_BEAT);

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch forms.
    state_nx = state;
    case (state)
      ST_IDLE: if (en && !empty)  state_nx = ST_ADDR;
      ST_ADDR: if (aw_hs)         state_nx = ST_DATA;
      ST_DATA: if (w_hs && wlast) state_nx = ST_RESP;
      ST_RESP: if (b_hs)          state_nx = ST_IDLE;
      default:                    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      state    <= ST_IDLE;
      pop_cnt  <= '0;
      beat_cnt <= '0;
      rd_en_q  <= 1'b0;
      awaddr   <= BASE_ADDR;
    end else begin
      state   <= state_nx;
      rd_en_q <= rd_en;
      if (state == ST_IDLE) begin
        pop_cnt  <= '0;
        beat_cnt <= '0;
      end else begin
        if (rd_en) pop_cnt  <= pop_cnt + 9'd1;
        if (w_hs)  beat_cnt <= beat_cnt + 8'd1;
      end
      if (b_hs) awaddr <= awaddr + ADDR_STEP;
    end
  end

`ifdef FIFO_AXI_WR_ERR_CNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else if (b_hs && (bresp != RESP_OKAY) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`else
  logic unused_bresp;

  assign unused_bresp = ^bresp;
  assign err_cnt      = '0;
`endif

endmodule
